if_stage_reg: RTL and testbench
===============================

# if_stage_reg

Instruction-fetch stage and IF/ID pipeline register for the pipelined MIPS datapath. It holds the program counter, drives the instruction-memory address, and captures the fetched word and PC+4 into the IF/ID register. The opcode field of that register feeds the Control decoder directly downstream. Control's `Jump` field, the EX-stage branch resolution and the hazard unit's stall steer the next PC back into this block.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `CNT_W`, default 32: width of the performance counters (used only with `IF_PERF_CNT_EN`).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: hazard-unit stall. Holds PC and IF/ID.
- `jump_sel` in 2: Control `Jump` for the IF/ID instruction. 00 sequential, 01 j, 10 jal, 11 jr.
- `jr_target` in 32: register value rs for jr.
- `branch_taken` in 1: EX-stage branch resolved taken.
- `branch_target` in 32: EX-stage branch target.
- `imem_addr` out 32: instruction-memory address, equal to the PC register.
- `imem_rdata` in 32: instruction word, combinational read of `imem_addr`.
- `if_id_instr` out 32: registered instruction.
- `if_id_pc4` out 32: registered PC+4 of that instruction, used by jal linking downstream.
- `if_id_valid` out 1: IF/ID holds a real instruction. 0 means bubble.
- `opcode` out 6: `if_id_instr[31:26]`, to Control.
- `fetch_cnt`, `stall_cnt`, `flush_cnt` out `CNT_W`: present only with `IF_PERF_CNT_EN`.

## Operation
- PC register drives `imem_addr` directly. `imem_rdata` is sampled at the same edge the PC advances.
- Next-state priority, evaluated every rising edge:
  1. **branch_taken = 1**
     - `pc <= branch_target`.
     - IF/ID becomes a bubble: instr 32'h0, pc4 32'h0, valid 0.
     - Overrides stall and jump, because the branch is the older instruction.
  2. **stall = 1**
     - PC, `if_id_instr`, `if_id_pc4` and `if_id_valid` hold.
     - A pending jump waits until the stall drops.
  3. **if_id_valid = 1 and jump_sel != 00**
     - j/jal: `pc <= {if_id_pc4[31:28], if_id_instr[25:0], 2'b00}`.
     - jr: `pc <= jr_target`.
     - IF/ID becomes a bubble.
  4. **Otherwise**
     - `pc <= pc + 4`.
     - `if_id_instr <= imem_rdata`, `if_id_pc4 <= pc + 4`, `if_id_valid <= 1`.
- `jump_sel` is ignored when `if_id_valid = 0`.
  - This prevents the bubble (opcode 000000, decoded as R-type) or a stale word from redirecting.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Low two PC bits are never forced. Targets are used exactly as supplied.
- This block does not flush ID/EX; downstream owns that.

## Timing
- Reset (`rst_n` low, asynchronous, takes effect without a clock edge):
  - `pc = RESET_PC`
  - `if_id_instr = 0`, `if_id_pc4 = 0`, `if_id_valid = 0`
  - all counters = 0
- First valid IF/ID word: the first rising edge after `rst_n` deasserts captures `mem[RESET_PC]`.
- Fetch-to-opcode latency: 1 cycle.
- Redirect penalty:
  - Jump: 1 bubble, since the jump is resolved in ID.
  - Taken branch: 1 bubble in IF/ID. The downstream ID/EX flush is separate.
- `opcode` is a pure slice of the register, so it is glitch-free relative to `clk`.

## Configuration
- `IF_PERF_CNT_EN` defined: three `CNT_W`-bit counters, which wrap on overflow and are cleared by reset.
  - `fetch_cnt` +1 on every priority-4 capture.
  - `stall_cnt` +1 on every edge with stall = 1 and branch_taken = 0.
  - `flush_cnt` +1 on every priority-1 or priority-3 bubble insertion.
- `IF_PERF_CNT_EN` undefined: counters and their ports are absent. Fetch behaviour is identical.

## Test plan
- **Reset release:** RESET_PC=0, imem holds its address as data, no stall. After 3 edges, pc=0x0C, if_id_instr=0x08, if_id_pc4=0x0C, valid=1, fetch_cnt=3.
- **Stall hold:** stall=1 for 2 edges with pc=0x08. pc stays 0x08, IF/ID unchanged, stall_cnt+=2. On release, pc=0x0C next edge.
- **j:** if_id_instr=32'h0800_0010, if_id_pc4=0x08, jump_sel=01. Next edge pc=0x40, if_id_instr=0, valid=0, flush_cnt+1. The following edge must not jump again.
- **jr:** jump_sel=11, jr_target=0x100, valid=1. Next edge pc=0x100, bubble.
- **Simultaneous events:** branch_taken=1, branch_target=0x200, stall=1, jump_sel=01 in the same cycle. pc=0x200, bubble, flush_cnt+1, stall_cnt unchanged.
- **Reset mid-run:** rst_n pulled low between edges at pc=0x40. pc=RESET_PC and valid=0 immediately, before the next edge; normal fetch resumes from RESET_PC after release.

Source files
------------

// File: rtl/if_stage_reg.sv
// Instruction-fetch stage and IF/ID pipeline register for the pipelined MIPS datapath.
// Define IF_PERF_CNT_EN to add fetch/stall/flush performance counters.
module if_stage_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [1:0]       jump_sel,
  input  logic [31:0]      jr_target,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc4,
  output logic             if_id_valid,
  output logic [5:0]       opcode
`ifdef IF_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;
  logic        fetch_ev, stall_ev, flush_ev;

  assign pc_plus4 = pc_q + 32'd4;

  // Branch is older than the jump in ID, so it wins; jumps only come from real instructions.
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    fetch_ev = 1'b0;
    stall_ev = 1'b0;
    flush_ev = 1'b0;
    if (branch_taken) begin
      pc_d     = branch_target;
      instr_d  = 32'h0;
      pc4_d    = 32'h0;
      valid_d  = 1'b0;
      flush_ev = 1'b1;
    end else if (stall) begin
      stall_ev = 1'b1;
    end else if (valid_q && (jump_sel != 2'b00)) begin
      pc_d     = (jump_sel == 2'b11) ? jr_target : {pc4_q[31:28], instr_q[25:0], 2'b00};
      instr_d  = 32'h0;
      pc4_d    = 32'h0;
      valid_d  = 1'b0;
      flush_ev = 1'b1;
    end else begin
      pc_d     = pc_plus4;
      instr_d  = imem_rdata;
      pc4_d    = pc_plus4;
      valid_d  = 1'b1;
      fetch_ev = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign opcode      = instr_q[31:26];

`ifdef IF_PERF_CNT_EN
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + CNT_W'(fetch_ev);
    stall_cnt_d = stall_cnt_q + CNT_W'(stall_ev);
    flush_cnt_d = flush_cnt_q + CNT_W'(flush_ev);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  logic unused_ev;
  assign unused_ev = fetch_ev ^ stall_ev ^ flush_ev;
`endif

endmodule

// File: tb/tb_if_stage_reg.sv
// Directed bench for if_stage_reg: each vector pushes its hand-computed post-edge state
// onto a scoreboard queue that a separate monitor pops and checks after every rising edge.
module tb_if_stage_reg;
  localparam int CNT_W = 32;

  typedef struct {
    logic [31:0] pc, instr, pc4;
    logic        valid;
    int          fc, sc, flc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  jump_sel = 2'b00;
  logic [31:0] jr_target = '0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] imem_addr, imem_rdata, if_id_instr, if_id_pc4;
  logic        if_id_valid;
  logic [5:0]  opcode;
`ifdef IF_PERF_CNT_EN
  logic [CNT_W-1:0] fetch_cnt, stall_cnt, flush_cnt;
`endif

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sbq[$];

  if_stage_reg #(.RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .jump_sel(jump_sel),
    .jr_target(jr_target), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .if_id_instr(if_id_instr),
    .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .opcode(opcode)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory returns its address as data, except a j to 0x40 stored at 0x0C.
  always_comb imem_rdata = (imem_addr == 32'h0C) ? 32'h0800_0010 : imem_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string tag, input exp_t e);
    chk({tag, " pc"}, imem_addr, e.pc);
    chk({tag, " instr"}, if_id_instr, e.instr);
    chk({tag, " pc4"}, if_id_pc4, e.pc4);
    chk({tag, " valid"}, {31'h0, if_id_valid}, {31'h0, e.valid});
    chk({tag, " opcode"}, {26'h0, opcode}, {26'h0, e.instr[31:26]});
`ifdef IF_PERF_CNT_EN
    chk({tag, " fetch_cnt"}, fetch_cnt, e.fc);
    chk({tag, " stall_cnt"}, stall_cnt, e.sc);
    chk({tag, " flush_cnt"}, flush_cnt, e.flc);
`endif
  endtask

  int step = 0;
  always @(posedge clk) begin
    #1;
    if (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      step++;
      chk_state($sformatf("step%0d", step), e);
    end
  end

  // Drive one cycle of inputs at the falling edge, queue the expected post-edge state.
  task automatic vec(input logic st, input logic br, input logic [31:0] bt,
                     input logic [1:0] js, input logic [31:0] jt,
                     input logic [31:0] epc, input logic [31:0] ei, input logic [31:0] ep4,
                     input logic ev, input int efc, input int esc, input int eflc);
    exp_t e;
    stall = st; branch_taken = br; branch_target = bt; jump_sel = js; jr_target = jt;
    e.pc = epc; e.instr = ei; e.pc4 = ep4; e.valid = ev; e.fc = efc; e.sc = esc; e.flc = eflc;
    sbq.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    exp_t r;
    r.pc = 32'h0; r.instr = 32'h0; r.pc4 = 32'h0; r.valid = 1'b0; r.fc = 0; r.sc = 0; r.flc = 0;
    #1 chk_state("reset", r);
    repeat (2) @(negedge clk);
    chk_state("reset_held", r);
    rst_n = 1'b1;
    //  st  br  bt            js     jt            pc            instr         pc4           v  fc sc fl
    vec(0, 0, 32'h0,         2'b00, 32'h0,        32'h4,        32'h0,        32'h4,        1, 1, 0, 0);
    vec(0, 0, 32'h0,         2'b00, 32'h0,        32'h8,        32'h4,        32'h8,        1, 2, 0, 0);
    vec(0, 0, 32'h0,         2'b00, 32'h0,        32'hC,        32'h8,        32'hC,        1, 3, 0, 0);
    vec(1, 0, 32'h0,         2'b00, 32'h0,        32'hC,        32'h8,        32'hC,        1, 3, 1, 0);
    vec(1, 0, 32'h0,         2'b00, 32'h0,        32'hC,        32'h8,        32'hC,        1, 3, 2, 0);
    vec(0, 0, 32'h0,         2'b00, 32'h0,        32'h10,       32'h0800_0010, 32'h10,      1, 4, 2, 0);
    vec(0, 0, 32'h0,         2'b01, 32'h0,        32'h40,       32'h0,        32'h0,        0, 4, 2, 1);
    vec(0, 0, 32'h0,         2'b01, 32'h0,        32'h44,       32'h40,       32'h44,       1, 5, 2, 1);
    vec(0, 0, 32'h0,         2'b11, 32'h100,      32'h100,      32'h0,        32'h0,        0, 5, 2, 2);
    vec(0, 0, 32'h0,         2'b00, 32'h0,        32'h104,      32'h100,      32'h104,      1, 6, 2, 2);
    vec(1, 1, 32'h200,       2'b01, 32'h0,        32'h200,      32'h0,        32'h0,        0, 6, 2, 3);
    vec(1, 0, 32'h0,         2'b01, 32'h0,        32'h200,      32'h0,        32'h0,        0, 6, 3, 3);
    vec(0, 0, 32'h0,         2'b00, 32'h0,        32'h204,      32'h200,      32'h204,      1, 7, 3, 3);
    vec(0, 1, 32'hFFFF_FFFC, 2'b00, 32'h0,        32'hFFFF_FFFC, 32'h0,       32'h0,        0, 7, 3, 4);
    vec(0, 0, 32'h0,         2'b00, 32'h0,        32'h0,        32'hFFFF_FFFC, 32'h0,       1, 8, 3, 4);
    vec(0, 0, 32'h0,         2'b11, 32'h302,      32'h302,      32'h0,        32'h0,        0, 8, 3, 5);
    vec(0, 0, 32'h0,         2'b00, 32'h0,        32'h306,      32'h302,      32'h306,      1, 9, 3, 5);
    vec(0, 1, 32'h40,        2'b00, 32'h0,        32'h40,       32'h0,        32'h0,        0, 9, 3, 6);
    branch_taken = 1'b0;
    // Asynchronous reset between edges must clear state without a clock.
    #2 rst_n = 1'b0;
    #1 chk_state("async_reset", r);
    @(negedge clk);
    chk_state("async_reset_held", r);
    rst_n = 1'b1;
    vec(0, 0, 32'h0,         2'b00, 32'h0,        32'h4,        32'h0,        32'h4,        1, 1, 0, 0);
    for (int i = 0; i < 5 && sbq.size() != 0; i++) @(negedge clk);
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
